// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec_ctrl
// Brief    : Execution controller feeding the ALU/barrel-shifter stage; holds
//            an 8-entry register file and NZCV flags, conditional writeback.
// Revision : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter int NUM = 8
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [20:0]    instr,
    input  logic           ld_en,
    input  logic [2:0]     ld_addr,
    input  logic [NUM-1:0] ld_data,
    output logic [NUM-1:0] alu_rn,
    output logic [NUM-1:0] alu_rm,
    output logic [2:0]     alu_amt,
    output logic [1:0]     alu_opbarrel,
    output logic [1:0]     alu_control,
    input  logic [NUM-1:0] alu_rd,
    input  logic           alu_n,
    input  logic           alu_z,
    input  logic           alu_v,
    input  logic           alu_c,
    output logic           done,
    output logic           executed,
    output logic [NUM-1:0] result,
    output logic [3:0]     flags_nzcv,
    input  logic [2:0]     dbg_addr,
    output logic [NUM-1:0] dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;

    logic [NUM-1:0] r_regs [0:7];
    logic [3:0]     r_flags;
    logic [3:0]     r_cap_flags;
    logic [NUM-1:0] r_res;
    logic           r_pass;
    logic [3:0]     r_cond;
    logic           r_s;
    logic [2:0]     r_rd;

    logic [NUM-1:0] r_alu_rn;
    logic [NUM-1:0] r_alu_rm;
    logic [2:0]     r_alu_amt;
    logic [1:0]     r_alu_opbarrel;
    logic [1:0]     r_alu_control;

    logic           w_accept;
    logic           w_cond_pass;
    logic           w_n;
    logic           w_z;
    logic           w_c;
    logic           w_v;

    assign in_ready     = (r_state == S_IDLE) && !ld_en && !reset;
    assign w_accept     = in_valid && in_ready;
    assign done         = (r_state == S_WB);
    assign executed     = done && r_pass;
    assign result       = r_res;
    assign flags_nzcv   = r_flags;
    assign dbg_data     = r_regs[dbg_addr];
    assign alu_rn       = r_alu_rn;
    assign alu_rm       = r_alu_rm;
    assign alu_amt      = r_alu_amt;
    assign alu_opbarrel = r_alu_opbarrel;
    assign alu_control  = r_alu_control;

    assign {w_n, w_z, w_c, w_v} = r_flags;

    // Condition is judged against the flags as they stood before this instruction.
    always_comb begin
        w_cond_pass = 1'b0;
        case (r_cond)
            4'h0:    w_cond_pass = w_z;
            4'h1:    w_cond_pass = !w_z;
            4'h2:    w_cond_pass = w_c;
            4'h3:    w_cond_pass = !w_c;
            4'h4:    w_cond_pass = w_c && !w_z;
            4'h5:    w_cond_pass = !w_c || w_z;
            4'h6:    w_cond_pass = (w_n == w_v);
            4'h7:    w_cond_pass = (w_n != w_v);
            4'h8:    w_cond_pass = !w_z && (w_n == w_v);
            4'h9:    w_cond_pass = w_z || (w_n != w_v);
            4'hA:    w_cond_pass = w_n;
            4'hB:    w_cond_pass = !w_n;
            4'hC:    w_cond_pass = w_v;
            4'hD:    w_cond_pass = !w_v;
            4'hE:    w_cond_pass = 1'b1;
            default: w_cond_pass = 1'b0;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_EXEC;
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            for (int i = 0; i < 8; i++) r_regs[i] <= '0;
            r_flags        <= 4'b0000;
            r_cap_flags    <= 4'b0000;
            r_res          <= '0;
            r_pass         <= 1'b0;
            r_cond         <= 4'h0;
            r_s            <= 1'b0;
            r_rd           <= 3'd0;
            r_alu_rn       <= '0;
            r_alu_rm       <= '0;
            r_alu_amt      <= 3'd0;
            r_alu_opbarrel <= 2'd0;
            r_alu_control  <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (ld_en) begin
                        r_regs[ld_addr] <= ld_data;
                    end else if (w_accept) begin
                        // Operands are sampled here, so rd==rn/rm needs no forwarding.
                        r_cond         <= instr[20:17];
                        r_s            <= instr[16];
                        r_alu_control  <= instr[15:14];
                        r_alu_opbarrel <= instr[13:12];
                        r_alu_amt      <= instr[11:9];
                        r_rd           <= instr[8:6];
                        r_alu_rn       <= r_regs[instr[5:3]];
                        r_alu_rm       <= r_regs[instr[2:0]];
                    end
                end
                S_EXEC: begin
                    r_res       <= alu_rd;
                    r_cap_flags <= {alu_n, alu_z, alu_c, alu_v};
                    r_pass      <= w_cond_pass;
                end
                S_WB: begin
                    if (r_pass) begin
                        r_regs[r_rd] <= r_res;
                        if (r_s) r_flags <= r_cap_flags;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
